// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the multicycle MIPS core. Serves single word
//   read/write requests over a non-pipelined Avalon-style slave port with
//   waitrequest, backed by a 2^ADDR_WIDTH-word RAM mapped at BASE_ADDR.
//   WAIT_STATES extra busy cycles are inserted before each access completes.
//
//   Optional feature macro: MEM_RESPONDER_ALIGN_CHECK_EN
//     defined   -> address[1:0] != 0 is flagged as an error (err pulse,
//                  no RAM write, read returns 0)
//     undefined -> address[1:0] is ignored
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   address      in   byte address from the CPU
//   read/write   in   request strobes
//   writedata    in   write data
//   byteenable   in   byte lane enables (bit i -> writedata[8i+7:8i])
//   readdata     out  registered read data, valid while waitrequest is low
//   waitrequest  out  high while a request has not yet been accepted
//   err          out  one-cycle pulse in the completion cycle of a failed access
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        err
);

    localparam int          DEPTH = 1 << ADDR_WIDTH;
    localparam int          CW    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    // One past the last mapped byte, kept 33 bits wide so a window ending at
    // the top of the 32-bit space does not wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              err_q, err_d;

    // Power-on contents are zero; reset never touches the array.
    logic [31:0]       mem [DEPTH] = '{default: 32'h0};

    logic              req;
    logic              do_access;
    logic [31:0]       acc_addr;
    logic              acc_rd, acc_wr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              in_range;
    logic              misalign;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic              mem_we;

    assign req         = read | write;
    assign waitrequest = req && (state_q != DONE);
    assign readdata    = readdata_q;
    assign err         = err_q;

    // With zero wait states the access happens on the IDLE edge itself, so the
    // live inputs are used; otherwise the latched copy is used.
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr  = address;
            acc_rd    = read;
            acc_wr    = write;
            acc_wdata = writedata;
            acc_be    = byteenable;
        end else begin
            acc_addr  = addr_q;
            acc_rd    = rd_q;
            acc_wr    = wr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    always_comb begin
        in_range = ({1'b0, acc_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, acc_addr} < LIMIT);
        acc_idx  = ADDR_WIDTH'((acc_addr - BASE_ADDR) >> 2);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        misalign = (acc_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        readdata_d = readdata_q;
        err_d      = 1'b0;
        do_access  = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = address;
                    rd_d    = read;
                    wr_d    = write;
                    wdata_d = writedata;
                    be_d    = byteenable;
                    if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = CW'(WAIT_STATES - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    // Master withdrew the request: drop it silently.
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            if (acc_rd && acc_wr) begin
                // Protocol error: readdata deliberately left untouched.
                err_d = 1'b1;
            end else if (!in_range || misalign) begin
                err_d = 1'b1;
                if (acc_rd) readdata_d = 32'h0;
            end else if (acc_rd) begin
                readdata_d = mem[acc_idx];
            end else begin
                mem_we = acc_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= 32'h0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            readdata_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
        end
    end

    // Lane-masked RAM write; reset blocks a write that would land on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle MIPS core: services the word read/write requests the control path raises (IorD-selected address, MemWrite) over an Avalon-style, non-pipelined slave interface with waitrequest.
- Holds a single-port word RAM of 2^ADDR_WIDTH words mapped at BASE_ADDR.
- Configurable wait states let the control FSM's memory-stall handling be exercised.

Parameters:
- ADDR_WIDTH, 10: word-address bits; RAM depth = 2^ADDR_WIDTH words.
- WAIT_STATES, 2: extra busy cycles inserted before each access completes (0 allowed).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word aligned.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- address  in  32  byte address from CPU
- read  in  1  read request
- write  in  1  write request
- writedata  in  32  write data
- byteenable  in  4  byte lane enables; bit i selects writedata[8i+7:8i]
- readdata  out  32  read data; valid in the cycle waitrequest is low with read high
- waitrequest  out  1  high = request not yet accepted; master holds all inputs stable
- err  out  1  one-cycle pulse flagging a failed transaction

Behaviour:
- Reset: state IDLE, wait counter 0, readdata 32'h0, err 0. RAM contents are not cleared; power-on contents are all zero.
- waitrequest is combinational: (read|write) && state!=DONE. It is low while idle with no request.
- Request latch: address, read/write, writedata and byteenable are latched on the IDLE edge where read|write=1. Later changes to these inputs are ignored.
- Range check: word index = (address-BASE_ADDR)>>2. The request is in range when BASE_ADDR <= address < BASE_ADDR + 4*2^ADDR_WIDTH. address[1:0] is ignored.
- FSM IDLE: on read|write:
  - WAIT_STATES==0: perform the access at this edge and go to DONE.
  - otherwise: go to BUSY with cnt=WAIT_STATES-1.
- FSM BUSY:
  - read|write both 0 (master abort): go to IDLE, no RAM write, readdata unchanged, no err.
  - cnt==0: perform the access and go to DONE.
  - otherwise: cnt decrements.
- FSM DONE: waitrequest low for exactly 1 cycle, then unconditionally go to IDLE. A back-to-back request is seen in IDLE the following cycle.
- Timing: waitrequest is high for WAIT_STATES+1 cycles from first assertion, then low for 1 cycle. Minimum spacing between transfers is WAIT_STATES+2 cycles.
- Write access: each lane with byteenable[i]=1 is updated; other lanes are kept. byteenable=0 writes nothing and is not an error.
- Read access: the full word is registered into readdata; byteenable is ignored. readdata holds its value until the next completed read.
- Error cases, each pulsing err high during the DONE cycle with no RAM write:
  - Out-of-range address: a read sets readdata to 32'h0.
  - read and write both high when latched: protocol error; readdata unchanged.
- Reset mid-transaction: immediate return to IDLE; a pending write is dropped and never performed; RAM contents are preserved.

Optional Feature:
- Macro: MEM_RESPONDER_ALIGN_CHECK_EN.
- Defined: a request with address[1:0]!=0 is a misalignment error. It completes with normal timing, pulses err, suppresses the RAM write, and a read returns 32'h0.
- Undefined: address[1:0] is ignored and misaligned requests are treated as word accesses with no err.

Test Plan:
- WAIT_STATES=2: write 0x10 with data 32'hDEADBEEF, be 4'hF -> waitrequest high 3 cycles, low 1, err 0. Then read 0x10 -> readdata 32'hDEADBEEF during the waitrequest-low cycle.
- After the above, write 0x10 with data 32'h0000AB00, be 4'b0010; then read 0x10 -> readdata 32'hDEADABEF.
- Read 0x1000 (ADDR_WIDTH=10, BASE 0) -> readdata 32'h0 with err high for exactly the 1 completion cycle; RAM word 0 unchanged.
- Write 0x20 with data 32'h1234, reset pulsed in the BUSY cycle -> FSM IDLE next cycle; a subsequent read 0x20 returns 32'h0.
- read=write=1 at 0x10 -> err pulse, readdata unchanged; read 0x10 still returns 32'hDEADABEF.
- WAIT_STATES=0 instance: back-to-back reads 0x0 and 0x4 -> waitrequest pattern 1,0,1,0; data returned in order. With MEM_RESPONDER_ALIGN_CHECK_EN, read 0x6 -> err pulse, readdata 32'h0.
